mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Load/store unit in the MEM position, directly downstream of the execute ALU.
- Consumes the ALU result as the effective address, plus the memory op code and the store data (rt).
- Drives a req/addr_ok/data_ok data-SRAM bus and returns a byte/halfword-extracted, extended load value.
- Stalls the pipeline while a transaction is outstanding, in the same style as the divider stall.

Parameters:
- KSEG_MAP, 1, when 1 addresses with [31:29]=100/101 map to {3'b000,addr[28:0]}; other addresses and KSEG_MAP=0 pass addr unchanged.
- ADDR_W, 32, physical address width driven on data_addr.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-low reset
- valid  in  1  MEM-stage instruction valid
- op  in  8  EXE_*_OP code; active codes LB/LBU/LH/LHU/LW/SB/SH/SW
- addr  in  32  effective virtual address (ALU y)
- wdata  in  32  store source register value
- flush  in  1  kill current instruction (exception/redirect)
- advance  in  1  pipeline moves MEM->WB this cycle
- data_req  out  1  bus request
- data_wr  out  1  1=store
- data_size  out  2  0=byte, 1=half, 2=word
- data_addr  out  ADDR_W  mapped address
- data_wstrb  out  4  byte enables
- data_wdata  out  32  lane-replicated store data
- data_addr_ok  in  1  request accepted
- data_data_ok  in  1  read data valid / write done
- data_rdata  in  32  raw read word
- mem_stall  out  1  hold pipeline
- rdata_out  out  32  extended load result
- rdata_valid  out  1  rdata_out valid (DONE state, load)
- adel  out  1  load address error
- ades  out  1  store address error
- badvaddr  out  32  faulting virtual address

Behaviour:
- Reset (rst=0, async): state IDLE, kill=0; all bus outputs, rdata_out, and rdata_valid are 0. A reset in the middle of REQ or WAIT abandons the transaction; any data_ok arriving after reset is ignored.
- States:
  - IDLE: on valid & mem-op & ~flush & ~exc, latch op/mapped addr/wdata, go to REQ.
  - REQ: data_req=1, bus fields held stable. On data_addr_ok go to WAIT. On flush, go to IDLE; legal only while addr_ok is not yet seen.
  - WAIT: on data_data_ok, capture the extended rdata and go to DONE. If kill is set, go to IDLE instead. A flush in WAIT sets kill; the transaction still completes.
  - DONE: result held. On advance or flush, go to IDLE.
- data_ok never arrives in the same cycle as addr_ok; only one transaction is outstanding at a time.
- mem_stall (combinational) = valid & mem-op & ~exc & ~flush & (state!=DONE). Minimum latency is 3 cycles from presentation to the DONE state.
- Store lanes:
  - SB: wstrb = 4'b0001 << addr[1:0]; wdata = {4{wdata[7:0]}}.
  - SH: wstrb = addr[1] ? 4'b1100 : 4'b0011; wdata = {2{wdata[15:0]}}.
  - SW: wstrb = 4'b1111.
  - Loads: wstrb = 0.
- Load extract: select the byte by addr[1:0] and the half by addr[1]. LB/LH sign-extend, LBU/LHU zero-extend, LW passes the word through.
- Exceptions are combinational from the inputs, gated by valid:
  - LH/LHU with addr[0]≠0, or LW with addr[1:0]≠0, raises adel.
  - SH/SW with the equivalent misalignment raises ades.
  - badvaddr = addr.
  - On an exception, no request is issued and mem_stall=0.
- Non-memory ops: no effect, all handshake outputs idle.

Optional Feature:
- MEM_ALIGN_CHECK_EN defined: the misalignment exceptions above apply.
- Undefined: adel/ades are tied to 0. The address low bits are forced to zero on the bus (half: [0], word: [1:0]), and lane selection uses the forced address.

Decomposition:
- Add to defines.vh: state encodings (MEM_IDLE/REQ/WAIT/DONE) and size codes (SIZE_B/H/W).
- Reuse the existing EXE_*_OP codes.
- One natural sub-module: mem_load_ext (op, addr[1:0], raw word -> extended 32-bit result), shared with WB forwarding.

Test Plan:
- LB, addr 0x80001003, rdata 0x80112233 -> data_addr 0x00001003, size 0, rdata_out 0xFFFFFF80. LBU with the same inputs -> 0x00000080.
- SH, addr 0x00001002, wdata 0x1234ABCD -> wstrb 4'b1100, data_wdata 0xABCDABCD, data_wr=1, size 1.
- LW at 0x00001001 with MEM_ALIGN_CHECK_EN -> adel=1, badvaddr 0x00001001, data_req never asserted, mem_stall=0.
- addr_ok delayed 3 cycles, data_ok 2 cycles later -> data_req and bus fields stable throughout, mem_stall high 6 cycles, then rdata_valid=1 until advance.
- Flush asserted in WAIT, then data_ok -> rdata_valid stays 0, state returns to IDLE, and the next LW issues normally.
- rst driven low in WAIT -> data_req=0 and state IDLE immediately; a data_ok arriving afterwards produces no rdata_valid.

Source files
------------

// File: rtl/mem_access_unit_pkg.sv
// Shared op codes, size codes, FSM states and lane helpers for the MEM-stage load/store unit.
// Latency: none (types and pure functions only).
// Backpressure: n/a.
package mem_access_unit_pkg;

  // Execute-stage op codes seen by the MEM stage
  localparam logic [7:0] EXE_NOP_OP = 8'h00;
  localparam logic [7:0] EXE_LB_OP  = 8'he0;
  localparam logic [7:0] EXE_LH_OP  = 8'he1;
  localparam logic [7:0] EXE_LW_OP  = 8'he3;
  localparam logic [7:0] EXE_LBU_OP = 8'he4;
  localparam logic [7:0] EXE_LHU_OP = 8'he5;
  localparam logic [7:0] EXE_SB_OP  = 8'he8;
  localparam logic [7:0] EXE_SH_OP  = 8'he9;
  localparam logic [7:0] EXE_SW_OP  = 8'heb;

  // Bus transfer size codes
  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  typedef enum logic [1:0] {
    MEM_IDLE = 2'd0,
    MEM_REQ  = 2'd1,
    MEM_WAIT = 2'd2,
    MEM_DONE = 2'd3
  } mem_state_e;

  function automatic logic is_load(input logic [7:0] op);
    is_load = (op == EXE_LB_OP) || (op == EXE_LBU_OP) || (op == EXE_LH_OP) ||
              (op == EXE_LHU_OP) || (op == EXE_LW_OP);
  endfunction

  function automatic logic is_store(input logic [7:0] op);
    is_store = (op == EXE_SB_OP) || (op == EXE_SH_OP) || (op == EXE_SW_OP);
  endfunction

  function automatic logic [1:0] op_size(input logic [7:0] op);
    case (op)
      EXE_LB_OP, EXE_LBU_OP, EXE_SB_OP: op_size = SIZE_B;
      EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP: op_size = SIZE_H;
      default:                          op_size = SIZE_W;
    endcase
  endfunction

  // A half must be 2-byte aligned, a word 4-byte aligned
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
    misaligned = ((size == SIZE_H) && lo[0]) || ((size == SIZE_W) && (lo != 2'b00));
  endfunction

  // Clear the address bits below the access size
  function automatic logic [31:0] force_align(input logic [31:0] a, input logic [1:0] size);
    case (size)
      SIZE_H:  force_align = {a[31:1], 1'b0};
      SIZE_W:  force_align = {a[31:2], 2'b00};
      default: force_align = a;
    endcase
  endfunction

  // kseg0/kseg1 are unmapped windows onto the low 512 MB
  function automatic logic [31:0] kseg_map(input logic [31:0] a, input logic en);
    if (en && ((a[31:29] == 3'b100) || (a[31:29] == 3'b101)))
      kseg_map = {3'b000, a[28:0]};
    else
      kseg_map = a;
  endfunction

  function automatic logic [3:0] strobe(input logic [1:0] size, input logic [1:0] lo,
                                        input logic st);
    if (!st)
      strobe = 4'b0000;
    else begin
      case (size)
        SIZE_B:  strobe = 4'b0001 << lo;
        SIZE_H:  strobe = lo[1] ? 4'b1100 : 4'b0011;
        default: strobe = 4'b1111;
      endcase
    end
  endfunction

  // Replicate the store source across every lane it could land in
  function automatic logic [31:0] lane_data(input logic [1:0] size, input logic [31:0] wd);
    case (size)
      SIZE_B:  lane_data = {4{wd[7:0]}};
      SIZE_H:  lane_data = {2{wd[15:0]}};
      default: lane_data = wd;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Data-SRAM bus: req/addr_ok address phase, data_ok completion phase.
// Latency: n/a (wires only).
// Backpressure: master holds req and fields until addr_ok; one transaction outstanding.
interface mem_access_unit_if #(
  parameter int ADDR_W = 32
);
  logic              data_req;
  logic              data_wr;
  logic [1:0]        data_size;
  logic [ADDR_W-1:0] data_addr;
  logic [3:0]        data_wstrb;
  logic [31:0]       data_wdata;
  logic              data_addr_ok;
  logic              data_data_ok;
  logic [31:0]       data_rdata;

  modport master (
    output data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
    input  data_addr_ok, data_data_ok, data_rdata
  );

  modport slave (
    input  data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
    output data_addr_ok, data_data_ok, data_rdata
  );
endinterface

// File: rtl/mem_access_unit_load_ext.sv
// Load lane extract: picks byte/half by address low bits and sign/zero extends.
// Latency: combinational.
// Backpressure: none.
module mem_load_ext
  import mem_access_unit_pkg::*;
(
  input  logic [7:0]  op,
  input  logic [1:0]  lo,
  input  logic [31:0] raw,
  output logic [31:0] ext
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane select then extend according to the load flavour
  always_comb begin
    case (lo)
      2'd0:    byte_sel = raw[7:0];
      2'd1:    byte_sel = raw[15:8];
      2'd2:    byte_sel = raw[23:16];
      default: byte_sel = raw[31:24];
    endcase
    half_sel = lo[1] ? raw[31:16] : raw[15:0];
    case (op)
      EXE_LB_OP:  ext = {{24{byte_sel[7]}}, byte_sel};
      EXE_LBU_OP: ext = {24'h0, byte_sel};
      EXE_LH_OP:  ext = {{16{half_sel[15]}}, half_sel};
      EXE_LHU_OP: ext = {16'h0, half_sel};
      default:    ext = raw;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: issues one data-SRAM transaction per memory op and returns the extended load value.
// Latency: 3 cycles minimum from presentation to DONE (IDLE -> REQ -> WAIT -> DONE).
// Backpressure: mem_stall holds the pipeline until DONE; bus fields stay stable until addr_ok.
// Build option: MEM_ALIGN_CHECK_EN enables adel/ades; otherwise misaligned low bits are forced to zero.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter bit KSEG_MAP = 1'b1,
  parameter int ADDR_W   = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                valid,
  input  logic [7:0]          op,
  input  logic [31:0]         addr,
  input  logic [31:0]         wdata,
  input  logic                flush,
  input  logic                advance,
  mem_access_unit_if.master   bus,
  output logic                mem_stall,
  output logic [31:0]         rdata_out,
  output logic                rdata_valid,
  output logic                adel,
  output logic                ades,
  output logic [31:0]         badvaddr
);

  logic        load_op;
  logic        store_op;
  logic        mem_op;
  logic [1:0]  size;
  logic [31:0] eff_addr;
  logic [31:0] paddr;
  logic        exc;
  logic        launch;
  logic [31:0] ext_dat;

  mem_state_e        state_q, state_d;
  logic              req_q, req_d;
  logic              wr_q, wr_d;
  logic [1:0]        size_q, size_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic [31:0]       wdat_q, wdat_d;
  logic [7:0]        op_q, op_d;
  logic [1:0]        lo_q, lo_d;
  logic              kill_q, kill_d;
  logic [31:0]       rdat_q, rdat_d;
  logic              rvld_q, rvld_d;

  assign load_op  = is_load(op);
  assign store_op = is_store(op);
  assign mem_op   = load_op | store_op;
  assign size     = op_size(op);

`ifdef MEM_ALIGN_CHECK_EN
  logic misal;
  assign misal    = misaligned(size, addr[1:0]);
  assign eff_addr = addr;
  assign adel     = valid & load_op & misal;
  assign ades     = valid & store_op & misal;
`else
  assign eff_addr = force_align(addr, size);
  assign adel     = 1'b0;
  assign ades     = 1'b0;
`endif

  assign exc       = adel | ades;
  assign paddr     = kseg_map(eff_addr, KSEG_MAP);
  assign badvaddr  = addr;
  assign launch    = valid & mem_op & ~flush & ~exc;
  assign mem_stall = valid & mem_op & ~exc & ~flush & (state_q != MEM_DONE);

  mem_load_ext u_load_ext (
    .op  (op_q),
    .lo  (lo_q),
    .raw (bus.data_rdata),
    .ext (ext_dat)
  );

  // Transaction FSM next-state and registered-output computation
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    wr_d    = wr_q;
    size_d  = size_q;
    addr_d  = addr_q;
    wstrb_d = wstrb_q;
    wdat_d  = wdat_q;
    op_d    = op_q;
    lo_d    = lo_q;
    kill_d  = kill_q;
    rdat_d  = rdat_q;
    rvld_d  = rvld_q;
    case (state_q)
      MEM_IDLE: begin
        if (launch) begin
          state_d = MEM_REQ;
          req_d   = 1'b1;
          wr_d    = store_op;
          size_d  = size;
          addr_d  = paddr[ADDR_W-1:0];
          wstrb_d = strobe(size, paddr[1:0], store_op);
          wdat_d  = store_op ? lane_data(size, wdata) : 32'h0;
          op_d    = op;
          lo_d    = paddr[1:0];
          kill_d  = 1'b0;
          rvld_d  = 1'b0;
        end
      end
      MEM_REQ: begin
        // Once accepted the bus owes us a data_ok, so a late flush only marks it dead
        if (bus.data_addr_ok) begin
          state_d = MEM_WAIT;
          req_d   = 1'b0;
          kill_d  = flush;
        end else if (flush) begin
          state_d = MEM_IDLE;
          req_d   = 1'b0;
        end
      end
      MEM_WAIT: begin
        if (bus.data_data_ok) begin
          if (kill_q || flush) begin
            state_d = MEM_IDLE;
            kill_d  = 1'b0;
          end else begin
            state_d = MEM_DONE;
            rdat_d  = ext_dat;
            rvld_d  = is_load(op_q);
          end
        end else if (flush) begin
          kill_d = 1'b1;
        end
      end
      MEM_DONE: begin
        if (advance || flush) begin
          state_d = MEM_IDLE;
          rvld_d  = 1'b0;
        end
      end
      default: begin
        state_d = MEM_IDLE;
        req_d   = 1'b0;
        rvld_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset abandons any outstanding transaction
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= MEM_IDLE;
      req_q   <= 1'b0;
      wr_q    <= 1'b0;
      size_q  <= 2'd0;
      addr_q  <= '0;
      wstrb_q <= 4'h0;
      wdat_q  <= 32'h0;
      op_q    <= EXE_NOP_OP;
      lo_q    <= 2'd0;
      kill_q  <= 1'b0;
      rdat_q  <= 32'h0;
      rvld_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      wr_q    <= wr_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      wstrb_q <= wstrb_d;
      wdat_q  <= wdat_d;
      op_q    <= op_d;
      lo_q    <= lo_d;
      kill_q  <= kill_d;
      rdat_q  <= rdat_d;
      rvld_q  <= rvld_d;
    end
  end

  assign bus.data_req   = req_q;
  assign bus.data_wr    = wr_q;
  assign bus.data_size  = size_q;
  assign bus.data_addr  = addr_q;
  assign bus.data_wstrb = wstrb_q;
  assign bus.data_wdata = wdat_q;
  assign rdata_out      = rdat_q;
  assign rdata_valid    = rvld_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: vector table of single transactions plus multi-cycle corner sequences.
// Latency: n/a.
// Backpressure: bench plays the SRAM slave and controls addr_ok/data_ok timing.
module tb_mem_access_unit
  import mem_access_unit_pkg::*;
;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid;
  logic [7:0]  op;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        flush;
  logic        advance;
  logic        mem_stall;
  logic [31:0] rdata_out;
  logic        rdata_valid;
  logic        adel;
  logic        ades;
  logic [31:0] badvaddr;

  int n_vec = 0;
  int n_err = 0;

  mem_access_unit_if #(.ADDR_W(32)) bus_if ();

  mem_access_unit dut (
    .clk         (clk),
    .rst         (rst),
    .valid       (valid),
    .op          (op),
    .addr        (addr),
    .wdata       (wdata),
    .flush       (flush),
    .advance     (advance),
    .bus         (bus_if),
    .mem_stall   (mem_stall),
    .rdata_out   (rdata_out),
    .rdata_valid (rdata_valid),
    .adel        (adel),
    .ades        (ades),
    .badvaddr    (badvaddr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [31:0] e_addr;
    logic [1:0]  e_size;
    logic        e_wr;
    logic [3:0]  e_wstrb;
    logic [31:0] e_wdata;
    logic [31:0] e_rdout;
  } vec_t;

  vec_t vt[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One transaction with single-cycle addr_ok and data_ok
  task automatic run_vec(input vec_t v, input string tag);
    valid = 1'b1; op = v.op; addr = v.addr; wdata = v.wdata;
    #1;
    check({tag, "_stall0"}, mem_stall, 1'b1);
    check({tag, "_exc"}, {adel, ades}, 2'b00);
    check({tag, "_badv"}, badvaddr, v.addr);
    for (int k = 0; k < 4 && !bus_if.data_req; k++) tick();
    check({tag, "_req"}, bus_if.data_req, 1'b1);
    check({tag, "_addr"}, bus_if.data_addr, v.e_addr);
    check({tag, "_size"}, bus_if.data_size, v.e_size);
    check({tag, "_wr"}, bus_if.data_wr, v.e_wr);
    check({tag, "_wstrb"}, bus_if.data_wstrb, v.e_wstrb);
    if (v.e_wr) check({tag, "_wdata"}, bus_if.data_wdata, v.e_wdata);
    bus_if.data_addr_ok = 1'b1;
    tick();
    bus_if.data_addr_ok = 1'b0;
    check({tag, "_req_wait"}, bus_if.data_req, 1'b0);
    bus_if.data_data_ok = 1'b1;
    bus_if.data_rdata   = v.rdata;
    tick();
    bus_if.data_data_ok = 1'b0;
    check({tag, "_stall_done"}, mem_stall, 1'b0);
    check({tag, "_rvld"}, rdata_valid, !v.e_wr);
    if (!v.e_wr) check({tag, "_rdout"}, rdata_out, v.e_rdout);
    advance = 1'b1;
    tick();
    advance = 1'b0; valid = 1'b0; op = EXE_NOP_OP;
    #1;
    check({tag, "_rvld_adv"}, rdata_valid, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    int stall_cnt;
    vt[0]  = '{EXE_LB_OP,  32'h80001003, 32'h0,        32'h80112233, 32'h00001003, SIZE_B, 1'b0, 4'b0000, 32'h0,        32'hFFFFFF80};
    vt[1]  = '{EXE_LBU_OP, 32'h80001003, 32'h0,        32'h80112233, 32'h00001003, SIZE_B, 1'b0, 4'b0000, 32'h0,        32'h00000080};
    vt[2]  = '{EXE_LH_OP,  32'hA0002002, 32'h0,        32'h80017FFF, 32'h00002002, SIZE_H, 1'b0, 4'b0000, 32'h0,        32'hFFFF8001};
    vt[3]  = '{EXE_LHU_OP, 32'h00002000, 32'h0,        32'h8001F00D, 32'h00002000, SIZE_H, 1'b0, 4'b0000, 32'h0,        32'h0000F00D};
    vt[4]  = '{EXE_LW_OP,  32'hC0000010, 32'h0,        32'hDEADBEEF, 32'hC0000010, SIZE_W, 1'b0, 4'b0000, 32'h0,        32'hDEADBEEF};
    vt[5]  = '{EXE_LB_OP,  32'h00000001, 32'h0,        32'h11223344, 32'h00000001, SIZE_B, 1'b0, 4'b0000, 32'h0,        32'h00000033};
    vt[6]  = '{EXE_SB_OP,  32'h80000002, 32'h000000A5, 32'h0,        32'h00000002, SIZE_B, 1'b1, 4'b0100, 32'hA5A5A5A5, 32'h0};
    vt[7]  = '{EXE_SH_OP,  32'h00001002, 32'h1234ABCD, 32'h0,        32'h00001002, SIZE_H, 1'b1, 4'b1100, 32'hABCDABCD, 32'h0};
    vt[8]  = '{EXE_SW_OP,  32'h00001000, 32'hCAFEF00D, 32'h0,        32'h00001000, SIZE_W, 1'b1, 4'b1111, 32'hCAFEF00D, 32'h0};
    vt[9]  = '{EXE_SH_OP,  32'h00000000, 32'h00005678, 32'h0,        32'h00000000, SIZE_H, 1'b1, 4'b0011, 32'h56785678, 32'h0};
    vt[10] = '{EXE_SB_OP,  32'h00000003, 32'h12345677, 32'h0,        32'h00000003, SIZE_B, 1'b1, 4'b1000, 32'h77777777, 32'h0};

    rst = 1'b0; valid = 1'b0; op = EXE_NOP_OP; addr = 32'h0; wdata = 32'h0;
    flush = 1'b0; advance = 1'b0;
    bus_if.data_addr_ok = 1'b0; bus_if.data_data_ok = 1'b0; bus_if.data_rdata = 32'h0;
    tick(); tick();
    check("rst_req", bus_if.data_req, 1'b0);
    check("rst_addr", bus_if.data_addr, 32'h0);
    check("rst_wstrb", bus_if.data_wstrb, 4'h0);
    check("rst_rdout", rdata_out, 32'h0);
    check("rst_rvld", rdata_valid, 1'b0);
    check("rst_stall", mem_stall, 1'b0);
    rst = 1'b1;
    tick();

    for (int i = 0; i < 11; i++) run_vec(vt[i], $sformatf("v%0d", i));

    // Non-memory op: nothing happens on the bus
    valid = 1'b1; op = 8'h25; addr = 32'h00001000;
    #1;
    check("nop_stall", mem_stall, 1'b0);
    tick();
    check("nop_req1", bus_if.data_req, 1'b0);
    tick();
    check("nop_req2", bus_if.data_req, 1'b0);
    valid = 1'b0; op = EXE_NOP_OP;
    tick();

`ifdef MEM_ALIGN_CHECK_EN
    valid = 1'b1; op = EXE_LW_OP; addr = 32'h00001001;
    #1;
    check("mis_lw_adel", adel, 1'b1);
    check("mis_lw_ades", ades, 1'b0);
    check("mis_lw_badv", badvaddr, 32'h00001001);
    check("mis_lw_stall", mem_stall, 1'b0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("mis_lw_req", bus_if.data_req, 1'b0);
    end
    op = EXE_SH_OP; addr = 32'h00001003;
    #1;
    check("mis_sh_ades", ades, 1'b1);
    check("mis_sh_adel", adel, 1'b0);
    check("mis_sh_stall", mem_stall, 1'b0);
    tick();
    check("mis_sh_req", bus_if.data_req, 1'b0);
    valid = 1'b0; op = EXE_NOP_OP;
    tick();
`else
    begin
      vec_t m0;
      vec_t m1;
      m0 = '{EXE_LW_OP, 32'h00001001, 32'h0,        32'h01020304, 32'h00001000, SIZE_W, 1'b0, 4'b0000, 32'h0,        32'h01020304};
      m1 = '{EXE_SH_OP, 32'h00001003, 32'h0000BEEF, 32'h0,        32'h00001002, SIZE_H, 1'b1, 4'b1100, 32'hBEEFBEEF, 32'h0};
      run_vec(m0, "force_lw");
      run_vec(m1, "force_sh");
    end
`endif

    // Slow slave: addr_ok on the third REQ cycle, data_ok two cycles after that
    valid = 1'b1; op = EXE_LW_OP; addr = 32'h00003000; stall_cnt = 0;
    bus_if.data_rdata = 32'h13579BDF;
    for (int c = 0; c < 9; c++) begin
      bus_if.data_addr_ok = (c == 3);
      bus_if.data_data_ok = (c == 5);
      advance = (c == 8);
      #1;
      if (mem_stall) stall_cnt++;
      if (c >= 1 && c <= 3) check($sformatf("dly_req_c%0d", c), bus_if.data_req, 1'b1);
      if (c == 4 || c == 5) check($sformatf("dly_req_wait_c%0d", c), bus_if.data_req, 1'b0);
      if (c >= 1 && c <= 5) begin
        check($sformatf("dly_addr_c%0d", c), bus_if.data_addr, 32'h00003000);
        check($sformatf("dly_size_c%0d", c), bus_if.data_size, SIZE_W);
      end
      if (c == 6 || c == 7) begin
        check($sformatf("dly_rvld_c%0d", c), rdata_valid, 1'b1);
        check($sformatf("dly_rdout_c%0d", c), rdata_out, 32'h13579BDF);
      end
      if (c <= 7 && c != 6 && c != 7) check($sformatf("dly_rvld0_c%0d", c), rdata_valid, 1'b0);
      tick();
    end
    valid = 1'b0; op = EXE_NOP_OP; advance = 1'b0;
    bus_if.data_addr_ok = 1'b0; bus_if.data_data_ok = 1'b0;
    check("dly_stall_cycles", stall_cnt, 6);
    check("dly_rvld_after_adv", rdata_valid, 1'b0);
    tick();

    // Flush while waiting for data: the completion is swallowed
    valid = 1'b1; op = EXE_LW_OP; addr = 32'h00004000;
    tick();
    check("fl_req", bus_if.data_req, 1'b1);
    bus_if.data_addr_ok = 1'b1;
    tick();
    bus_if.data_addr_ok = 1'b0;
    flush = 1'b1;
    #1;
    check("fl_stall", mem_stall, 1'b0);
    tick();
    flush = 1'b0; valid = 1'b0; op = EXE_NOP_OP;
    bus_if.data_data_ok = 1'b1; bus_if.data_rdata = 32'hFFFFFFFF;
    tick();
    bus_if.data_data_ok = 1'b0;
    check("fl_rvld", rdata_valid, 1'b0);
    check("fl_req_idle", bus_if.data_req, 1'b0);
    tick();
    check("fl_rvld2", rdata_valid, 1'b0);
    run_vec(vt[4], "fl_next_lw");

    // Reset while REQ is up drops data_req without a clock edge
    valid = 1'b1; op = EXE_LW_OP; addr = 32'h00005000;
    tick();
    check("rq_rst_req1", bus_if.data_req, 1'b1);
    valid = 1'b0; op = EXE_NOP_OP;
    #2;
    rst = 1'b0;
    #1;
    check("rq_rst_req0", bus_if.data_req, 1'b0);
    tick();
    rst = 1'b1;
    tick();

    // Reset in WAIT: a late data_ok must be ignored
    valid = 1'b1; op = EXE_LW_OP; addr = 32'h00005000;
    tick();
    bus_if.data_addr_ok = 1'b1;
    tick();
    bus_if.data_addr_ok = 1'b0;
    valid = 1'b0; op = EXE_NOP_OP;
    rst = 1'b0;
    #1;
    check("wt_rst_req", bus_if.data_req, 1'b0);
    check("wt_rst_rvld", rdata_valid, 1'b0);
    tick();
    rst = 1'b1;
    bus_if.data_data_ok = 1'b1; bus_if.data_rdata = 32'h55AA55AA;
    tick();
    bus_if.data_data_ok = 1'b0;
    check("wt_late_rvld", rdata_valid, 1'b0);
    check("wt_late_rdout", rdata_out, 32'h0);
    tick();
    check("wt_late_rvld2", rdata_valid, 1'b0);
    check("wt_late_req", bus_if.data_req, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
